// File: rtl/dbus_pkg.sv
// Shared types and helpers for the data-bus crossbar (dbus_xbar, dbus_addr_dec).
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STRB = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } dbus_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Width of a slave index; a single-slave build still gets a 1-bit index.
    function automatic int slv_idx_w(input int n);
        return $clog2(n > 1 ? n : 2);
    endfunction

endpackage

// File: rtl/dbus_addr_dec.sv
// Combinational base/mask address decoder: hit flag, one-hot match, encoded index
// and slave-local offset. Overlapping regions resolve to the lowest slave index.
module dbus_addr_dec
    import dbus_pkg::*;
#(
    parameter int ADDR_LEN = 14,
    parameter int NUM_SLV  = 3,
    parameter logic [NUM_SLV*ADDR_LEN-1:0] SLV_BASE = {14'h3000, 14'h2000, 14'h0000},
    parameter logic [NUM_SLV*ADDR_LEN-1:0] SLV_MASK = {3{14'h3000}},
    parameter int SEL_W = slv_idx_w(NUM_SLV)
) (
    input  logic [ADDR_LEN-1:0] addr,
    output logic                hit,
    output logic [NUM_SLV-1:0]  match,
    output logic [SEL_W-1:0]    idx,
    output logic [ADDR_LEN-1:0] offset
);

    // Scan from the highest index down so the lowest matching slave overrides.
    always_comb begin
        hit    = 1'b0;
        match  = '0;
        idx    = '0;
        offset = addr;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_LEN +: ADDR_LEN]) == SLV_BASE[i*ADDR_LEN +: ADDR_LEN]) begin
                hit      = 1'b1;
                match    = '0;
                match[i] = 1'b1;
                idx      = SEL_W'(i);
                offset   = addr & ~SLV_MASK[i*ADDR_LEN +: ADDR_LEN];
            end
        end
    end

endmodule

// File: rtl/dbus_xbar.sv
// Data-bus crossbar: one master, NUM_SLV memory-mapped slaves, error response on
// unmapped or (with DBUS_TIMEOUT_EN defined) hung slaves.
module dbus_xbar
    import dbus_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_LEN = 14,
    parameter int NUM_SLV  = 3,
    parameter logic [NUM_SLV*ADDR_LEN-1:0] SLV_BASE = {14'h3000, 14'h2000, 14'h0000},
    parameter logic [NUM_SLV*ADDR_LEN-1:0] SLV_MASK = {3{14'h3000}},
    parameter logic [XLEN-1:0] ERR_DATA = XLEN'(ERR_DATA_DEFAULT),
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_LEN-1:0]      m_addr,
    input  logic                     m_rd_req,
    input  logic                     m_wr_req,
    input  logic [XLEN/8-1:0]        m_wr_be,
    input  logic [XLEN-1:0]          m_wr_data,
    output logic                     m_rd_ready,
    output logic                     m_wr_ready,
    output logic [XLEN-1:0]          m_rd_data,
    output logic                     m_err,
    output logic [ADDR_LEN-1:0]      s_addr,
    output logic [XLEN-1:0]          s_wr_data,
    output logic [XLEN/8-1:0]        s_be,
    output logic [NUM_SLV-1:0]       s_rd_en,
    output logic [NUM_SLV-1:0]       s_wr_en,
    input  logic [NUM_SLV*XLEN-1:0]  s_rd_data,
    input  logic [NUM_SLV-1:0]       s_ready
);

    localparam int SEL_W = slv_idx_w(NUM_SLV);

    dbus_state_t         state;
    logic                dir_wr;
    logic                err_q;
    logic [SEL_W-1:0]    sel_q;
    logic [NUM_SLV-1:0]  match_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN/8-1:0]   be_q;
    logic [XLEN-1:0]     rdata_q;

    logic                dec_hit;
    logic [NUM_SLV-1:0]  dec_match;
    logic [SEL_W-1:0]    dec_idx;
    logic [ADDR_LEN-1:0] dec_offset;

    logic                ready_sel;
    logic [XLEN-1:0]     rdata_sel;

`ifdef DBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt;
`endif

    dbus_addr_dec #(
        .ADDR_LEN (ADDR_LEN),
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .SEL_W    (SEL_W)
    ) u_dec (
        .addr   (m_addr),
        .hit    (dec_hit),
        .match  (dec_match),
        .idx    (dec_idx),
        .offset (dec_offset)
    );

    assign ready_sel = s_ready[sel_q];
    assign rdata_sel = s_rd_data[sel_q*XLEN +: XLEN];

    // A decode miss skips the slave entirely and preloads the error word so RESP
    // can present rdata_q unconditionally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dir_wr  <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            match_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
`ifdef DBUS_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m_rd_req || m_wr_req) begin
                        dir_wr  <= m_wr_req;
                        err_q   <= !dec_hit;
                        sel_q   <= dec_idx;
                        match_q <= dec_match;
                        addr_q  <= dec_offset;
                        wdata_q <= m_wr_data;
                        be_q    <= m_wr_be;
                        rdata_q <= dec_hit ? '0 : ERR_DATA;
                        state   <= dec_hit ? STRB : RESP;
                    end
                end
                STRB: begin
`ifdef DBUS_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    if (ready_sel) begin
                        rdata_q <= dir_wr ? '0 : rdata_sel;
                        state   <= RESP;
                    end else begin
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (ready_sel) begin
                        rdata_q <= dir_wr ? '0 : rdata_sel;
                        state   <= RESP;
                    end
`ifdef DBUS_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_q   <= 1'b1;
                        rdata_q <= ERR_DATA;
                        state   <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign s_addr     = addr_q;
    assign s_wr_data  = wdata_q;
    assign s_be       = be_q;
    assign s_rd_en    = (state == STRB && !dir_wr) ? match_q : '0;
    assign s_wr_en    = (state == STRB &&  dir_wr) ? match_q : '0;
    assign m_rd_ready = (state == RESP) && !dir_wr;
    assign m_wr_ready = (state == RESP) &&  dir_wr;
    assign m_err      = (state == RESP) && err_q;
    assign m_rd_data  = m_rd_ready ? rdata_q : '0;

endmodule

// File: tb/tb_dbus_xbar.sv
// Self-checking bench for dbus_xbar: behavioural slave model plus a response scoreboard.
module tb_dbus_xbar;

    localparam int XLEN = 32;
    localparam int ADDR_LEN = 14;
    localparam int NUM_SLV = 3;
    localparam logic [31:0] RD0 = 32'h1234_5678;
    localparam logic [31:0] RD1 = 32'hCAFE_0001;
    localparam logic [31:0] RD2 = 32'hA5A5_5A5A;

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [ADDR_LEN-1:0]     m_addr;
    logic                    m_rd_req;
    logic                    m_wr_req;
    logic [XLEN/8-1:0]       m_wr_be;
    logic [XLEN-1:0]         m_wr_data;
    logic                    m_rd_ready;
    logic                    m_wr_ready;
    logic [XLEN-1:0]         m_rd_data;
    logic                    m_err;
    logic [ADDR_LEN-1:0]     s_addr;
    logic [XLEN-1:0]         s_wr_data;
    logic [XLEN/8-1:0]       s_be;
    logic [NUM_SLV-1:0]      s_rd_en;
    logic [NUM_SLV-1:0]      s_wr_en;
    logic [NUM_SLV*XLEN-1:0] s_rd_data;
    logic [NUM_SLV-1:0]      s_ready;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    exp_t exp_q[$];

    // Slave model configuration (delay -1 = never ready) and strobe observations.
    int slv_delay[NUM_SLV];
    int late_req = 0;
    int n_strobe = 0;
    int strobe_cyc = 0;
    logic strobe_wr = 1'b0;
    logic [NUM_SLV-1:0] strobe_vec = '0;
    logic [ADDR_LEN-1:0] strobe_addr = '0;
    logic [XLEN-1:0] strobe_wdata = '0;
    logic [XLEN/8-1:0] strobe_be = '0;

    logic got_rd, got_wr, got_err;
    logic [31:0] got_data;
    int got_cyc;

    assign s_rd_data = {RD2, RD1, RD0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbus_xbar #(
        .XLEN        (XLEN),
        .ADDR_LEN    (ADDR_LEN),
        .NUM_SLV     (NUM_SLV),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_addr     (m_addr),
        .m_rd_req   (m_rd_req),
        .m_wr_req   (m_wr_req),
        .m_wr_be    (m_wr_be),
        .m_wr_data  (m_wr_data),
        .m_rd_ready (m_rd_ready),
        .m_wr_ready (m_wr_ready),
        .m_rd_data  (m_rd_data),
        .m_err      (m_err),
        .s_addr     (s_addr),
        .s_wr_data  (s_wr_data),
        .s_be       (s_be),
        .s_rd_en    (s_rd_en),
        .s_wr_en    (s_wr_en),
        .s_rd_data  (s_rd_data),
        .s_ready    (s_ready)
    );

    // Slave model: answers a strobe after slv_delay cycles, on the falling edge.
    initial begin
        int pend_cnt;
        int pend_idx;
        int late_seen;
        logic pend;
        pend = 1'b0;
        pend_cnt = 0;
        pend_idx = 0;
        late_seen = 0;
        s_ready = '0;
        forever begin
            @(negedge clk);
            s_ready = '0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (late_req != late_seen) begin
                    s_ready[2] = 1'b1;
                    late_seen = late_req;
                end
                if (pend) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        s_ready[pend_idx] = 1'b1;
                        pend = 1'b0;
                    end
                end else if (|(s_rd_en | s_wr_en)) begin
                    int idx;
                    idx = 0;
                    for (int i = 0; i < NUM_SLV; i++)
                        if (s_rd_en[i] || s_wr_en[i]) idx = i;
                    n_strobe++;
                    strobe_cyc   = cyc;
                    strobe_wr    = |s_wr_en;
                    strobe_vec   = s_rd_en | s_wr_en;
                    strobe_addr  = s_addr;
                    strobe_wdata = s_wr_data;
                    strobe_be    = s_be;
                    if (slv_delay[idx] == 0) begin
                        s_ready[idx] = 1'b1;
                    end else if (slv_delay[idx] > 0) begin
                        pend = 1'b1;
                        pend_cnt = slv_delay[idx];
                        pend_idx = idx;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int max_cyc, output int lat, output logic timed_out);
        lat = 0;
        timed_out = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            tick();
            if (m_rd_ready || m_wr_ready) begin
                lat = k;
                timed_out = 1'b0;
                got_rd = m_rd_ready;
                got_wr = m_wr_ready;
                got_err = m_err;
                got_data = m_rd_data;
                got_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++; if ({m_rd_ready, m_wr_ready, m_err} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_flags got=%b exp=000", {m_rd_ready, m_wr_ready, m_err}); end
        n_cmp++; if (m_rd_data !== 32'h0) begin n_err++; $display("[TB] FAIL reset_rdata got=%h exp=0", m_rd_data); end
        n_cmp++; if ({s_rd_en, s_wr_en} !== 6'b0) begin n_err++; $display("[TB] FAIL reset_strobes got=%b exp=0", {s_rd_en, s_wr_en}); end
        n_cmp++; if ({s_addr, s_wr_data, s_be} !== '0) begin n_err++; $display("[TB] FAIL reset_slave_bus got=%h exp=0", {s_addr, s_wr_data, s_be}); end
    endtask

    task automatic test_read_same_cycle();
        int lat; logic to; exp_t e; int s0;
        s0 = n_strobe;
        slv_delay[0] = 0;
        exp_q.push_back('{wr: 1'b0, err: 1'b0, data: RD0});
        m_addr = 14'h0040; m_rd_req = 1'b1;
        wait_resp(10, lat, to);
        m_rd_req = 1'b0;
        if (to) begin n_cmp++; n_err++; $display("[TB] FAIL t1_no_response"); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if ({got_rd, got_wr} !== {!e.wr, e.wr}) begin n_err++; $display("[TB] FAIL t1_kind got=%b%b exp=%b%b", got_rd, got_wr, !e.wr, e.wr); end
            n_cmp++; if (got_data !== e.data) begin n_err++; $display("[TB] FAIL t1_data got=%h exp=%h", got_data, e.data); end
            n_cmp++; if (got_err !== e.err) begin n_err++; $display("[TB] FAIL t1_err got=%b exp=%b", got_err, e.err); end
            n_cmp++; if (lat !== 2) begin n_err++; $display("[TB] FAIL t1_latency got=%0d exp=2", lat); end
        end
        n_cmp++; if (n_strobe - s0 !== 1 || strobe_vec !== 3'b001 || strobe_wr !== 1'b0) begin n_err++; $display("[TB] FAIL t1_strobe got=%0d/%b/%b exp=1/001/0", n_strobe - s0, strobe_vec, strobe_wr); end
        n_cmp++; if (strobe_addr !== 14'h0040) begin n_err++; $display("[TB] FAIL t1_s_addr got=%h exp=0040", strobe_addr); end
        tick();
        n_cmp++; if ({m_rd_ready, m_rd_data} !== '0) begin n_err++; $display("[TB] FAIL t1_idle_after got=%b/%h exp=0/0", m_rd_ready, m_rd_data); end
    endtask

    task automatic test_write_wait();
        int lat; logic to; exp_t e; int s0;
        s0 = n_strobe;
        slv_delay[1] = 3;
        exp_q.push_back('{wr: 1'b1, err: 1'b0, data: 32'h0});
        m_addr = 14'h2004; m_wr_be = 4'b0010; m_wr_data = 32'h0000_4100; m_wr_req = 1'b1;
        wait_resp(20, lat, to);
        m_wr_req = 1'b0;
        if (to) begin n_cmp++; n_err++; $display("[TB] FAIL t2_no_response"); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if ({got_rd, got_wr} !== {!e.wr, e.wr}) begin n_err++; $display("[TB] FAIL t2_kind got=%b%b exp=%b%b", got_rd, got_wr, !e.wr, e.wr); end
            n_cmp++; if ({got_err, got_data} !== {e.err, e.data}) begin n_err++; $display("[TB] FAIL t2_err_data got=%b/%h exp=%b/%h", got_err, got_data, e.err, e.data); end
            n_cmp++; if (lat !== 5) begin n_err++; $display("[TB] FAIL t2_latency got=%0d exp=5", lat); end
        end
        n_cmp++; if (n_strobe - s0 !== 1 || strobe_vec !== 3'b010 || strobe_wr !== 1'b1) begin n_err++; $display("[TB] FAIL t2_strobe got=%0d/%b/%b exp=1/010/1", n_strobe - s0, strobe_vec, strobe_wr); end
        n_cmp++; if ({strobe_addr, strobe_be, strobe_wdata} !== {14'h0004, 4'b0010, 32'h0000_4100}) begin n_err++; $display("[TB] FAIL t2_slave_bus got=%h/%b/%h exp=0004/0010/00004100", strobe_addr, strobe_be, strobe_wdata); end
        tick();
    endtask

    task automatic test_decode_miss();
        int lat; logic to; exp_t e; int s0;
        s0 = n_strobe;
        exp_q.push_back('{wr: 1'b0, err: 1'b1, data: 32'hDEAD_BEEF});
        m_addr = 14'h1000; m_rd_req = 1'b1;
        wait_resp(10, lat, to);
        m_rd_req = 1'b0;
        if (to) begin n_cmp++; n_err++; $display("[TB] FAIL t3_no_response"); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if ({got_rd, got_wr} !== {!e.wr, e.wr}) begin n_err++; $display("[TB] FAIL t3_kind got=%b%b exp=%b%b", got_rd, got_wr, !e.wr, e.wr); end
            n_cmp++; if ({got_err, got_data} !== {e.err, e.data}) begin n_err++; $display("[TB] FAIL t3_err_data got=%b/%h exp=%b/%h", got_err, got_data, e.err, e.data); end
            n_cmp++; if (lat !== 1) begin n_err++; $display("[TB] FAIL t3_latency got=%0d exp=1", lat); end
        end
        tick();
        n_cmp++; if (n_strobe !== s0) begin n_err++; $display("[TB] FAIL t3_no_strobe got=%0d exp=%0d", n_strobe, s0); end
        // Write miss is dropped: error completion, still no strobe.
        exp_q.push_back('{wr: 1'b1, err: 1'b1, data: 32'h0});
        m_addr = 14'h1ABC; m_wr_data = 32'h5555_AAAA; m_wr_be = 4'hF; m_wr_req = 1'b1;
        wait_resp(10, lat, to);
        m_wr_req = 1'b0;
        if (to) begin n_cmp++; n_err++; $display("[TB] FAIL t3w_no_response"); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if ({got_wr, got_err, got_data} !== {e.wr, e.err, e.data}) begin n_err++; $display("[TB] FAIL t3w_resp got=%b/%b/%h exp=%b/%b/%h", got_wr, got_err, got_data, e.wr, e.err, e.data); end
        end
        tick();
        n_cmp++; if (n_strobe !== s0) begin n_err++; $display("[TB] FAIL t3w_no_strobe got=%0d exp=%0d", n_strobe, s0); end
    endtask

    task automatic test_back_to_back();
        int lat; logic to; exp_t e; int s0; int wr_cyc;
        s0 = n_strobe;
        slv_delay[2] = 0;
        exp_q.push_back('{wr: 1'b1, err: 1'b0, data: 32'h0});
        exp_q.push_back('{wr: 1'b0, err: 1'b0, data: RD2});
        m_addr = 14'h3008; m_wr_data = 32'h0BAD_F00D; m_wr_be = 4'b1100;
        m_rd_req = 1'b1; m_wr_req = 1'b1;
        wait_resp(10, lat, to);
        m_wr_req = 1'b0;
        wr_cyc = got_cyc;
        if (to) begin n_cmp++; n_err++; $display("[TB] FAIL t4_no_write_response"); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if ({got_rd, got_wr, got_err} !== {!e.wr, e.wr, e.err}) begin n_err++; $display("[TB] FAIL t4_first_is_write got=%b%b%b exp=%b%b%b", got_rd, got_wr, got_err, !e.wr, e.wr, e.err); end
            n_cmp++; if (strobe_wr !== 1'b1 || strobe_vec !== 3'b100 || strobe_addr !== 14'h0008) begin n_err++; $display("[TB] FAIL t4_write_strobe got=%b/%b/%h exp=1/100/0008", strobe_wr, strobe_vec, strobe_addr); end
        end
        wait_resp(10, lat, to);
        m_rd_req = 1'b0;
        if (to) begin n_cmp++; n_err++; $display("[TB] FAIL t4_no_read_response"); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if ({got_rd, got_err, got_data} !== {!e.wr, e.err, e.data}) begin n_err++; $display("[TB] FAIL t4_read got=%b/%b/%h exp=%b/%b/%h", got_rd, got_err, got_data, !e.wr, e.err, e.data); end
            n_cmp++; if (n_strobe - s0 !== 2 || strobe_wr !== 1'b0 || strobe_vec !== 3'b100) begin n_err++; $display("[TB] FAIL t4_read_strobe got=%0d/%b/%b exp=2/0/100", n_strobe - s0, strobe_wr, strobe_vec); end
            n_cmp++; if (strobe_cyc - wr_cyc < 1 || strobe_cyc - wr_cyc > 2) begin n_err++; $display("[TB] FAIL t4_read_strobe_gap got=%0d exp=1..2", strobe_cyc - wr_cyc); end
        end
        tick();
    endtask

`ifdef DBUS_TIMEOUT_EN
    task automatic test_slave_wait();
        int lat; logic to; exp_t e;
        slv_delay[2] = -1;
        exp_q.push_back('{wr: 1'b0, err: 1'b1, data: 32'hDEAD_BEEF});
        m_addr = 14'h3000; m_rd_req = 1'b1;
        wait_resp(20, lat, to);
        m_rd_req = 1'b0;
        if (to) begin n_cmp++; n_err++; $display("[TB] FAIL t5_no_timeout"); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if ({got_rd, got_err, got_data} !== {!e.wr, e.err, e.data}) begin n_err++; $display("[TB] FAIL t5_timeout_resp got=%b/%b/%h exp=%b/%b/%h", got_rd, got_err, got_data, !e.wr, e.err, e.data); end
            n_cmp++; if (lat !== 6) begin n_err++; $display("[TB] FAIL t5_latency got=%0d exp=6", lat); end
        end
        late_req++;
        wait_resp(5, lat, to);
        n_cmp++; if (to !== 1'b1) begin n_err++; $display("[TB] FAIL t5_spurious_ready got=%b exp=1", to); end
        slv_delay[2] = 0;
    endtask
`else
    task automatic test_slave_wait();
        int lat; logic to; exp_t e;
        slv_delay[1] = 70;
        exp_q.push_back('{wr: 1'b0, err: 1'b0, data: RD1});
        m_addr = 14'h2010; m_rd_req = 1'b1;
        wait_resp(100, lat, to);
        m_rd_req = 1'b0;
        if (to) begin n_cmp++; n_err++; $display("[TB] FAIL t5_no_response"); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if ({got_rd, got_err, got_data} !== {!e.wr, e.err, e.data}) begin n_err++; $display("[TB] FAIL t5_long_wait got=%b/%b/%h exp=%b/%b/%h", got_rd, got_err, got_data, !e.wr, e.err, e.data); end
            n_cmp++; if (lat !== 72) begin n_err++; $display("[TB] FAIL t5_latency got=%0d exp=72", lat); end
        end
        tick();
    endtask
`endif

    task automatic test_reset_in_wait();
        int lat; logic to; exp_t e;
        slv_delay[0] = -1;
        exp_q.push_back('{wr: 1'b0, err: 1'b0, data: RD0});
        m_addr = 14'h0044; m_rd_req = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        exp_q.delete();
        #1;
        n_cmp++; if ({m_rd_ready, m_wr_ready, m_err, m_rd_data, s_rd_en, s_wr_en, s_addr} !== '0) begin n_err++; $display("[TB] FAIL t6_outputs_in_reset got=%b%b%b/%h/%b/%b/%h exp=0", m_rd_ready, m_wr_ready, m_err, m_rd_data, s_rd_en, s_wr_en, s_addr); end
        m_rd_req = 1'b0;
        tick();
        rst = 1'b0;
        slv_delay[0] = 0;
        tick();
        exp_q.push_back('{wr: 1'b0, err: 1'b0, data: RD0});
        m_addr = 14'h0000; m_rd_req = 1'b1;
        wait_resp(10, lat, to);
        m_rd_req = 1'b0;
        if (to) begin n_cmp++; n_err++; $display("[TB] FAIL t6_no_response"); end
        else begin
            e = exp_q.pop_front();
            n_cmp++; if ({got_rd, got_err, got_data} !== {!e.wr, e.err, e.data}) begin n_err++; $display("[TB] FAIL t6_after_reset got=%b/%b/%h exp=%b/%b/%h", got_rd, got_err, got_data, !e.wr, e.err, e.data); end
            n_cmp++; if (lat !== 2) begin n_err++; $display("[TB] FAIL t6_latency got=%0d exp=2", lat); end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        m_addr = '0; m_rd_req = 1'b0; m_wr_req = 1'b0; m_wr_be = '0; m_wr_data = '0;
        for (int i = 0; i < NUM_SLV; i++) slv_delay[i] = 0;
        #2;
        test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        $display("[TB] read, same-cycle slave");
        test_read_same_cycle();
        $display("[TB] write, waiting slave");
        test_write_wait();
        $display("[TB] unmapped accesses");
        test_decode_miss();
        $display("[TB] simultaneous write and read");
        test_back_to_back();
        $display("[TB] slow or hung slave");
        test_slave_wait();
        $display("[TB] reset during wait");
        test_reset_in_wait();
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("[TB] FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
